// File: rtl/lbdr_reconf.sv
`default_nettype none
//============================================================================
// Module   : lbdr_reconf
// Purpose  : Logic-Based Distributed Routing unit for a 2D mesh router
//            input port, with runtime-reconfigurable routing (Rxy) and
//            connectivity (Cx) bits. A packet's header selects the output
//            port(s), which stay latched until the tail flit has passed.
// Options  : LBDR_ERR_CNT_EN - when defined, err_cnt is a saturating 8-bit
//            count of cycles carrying route_err or proto_err; otherwise
//            err_cnt is tied to zero.
// Revision : 1.0 - initial release
//============================================================================
module lbdr_reconf #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int A_W = X_W + Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           empty,
  input  logic [2:0]     flit_id,
  input  logic [A_W-1:0] dst_addr,
  input  logic [7:0]     Rxy_rst,
  input  logic [3:0]     Cx_rst,
  input  logic [A_W-1:0] cur_addr_rst,
  input  logic           cfg_we,
  input  logic [7:0]     Rxy_cfg,
  input  logic [3:0]     Cx_cfg,
  output logic           Nport,
  output logic           Eport,
  output logic           Wport,
  output logic           Sport,
  output logic           Lport,
  output logic           busy,
  output logic           route_err,
  output logic           proto_err,
  output logic [7:0]     err_cnt
);

  localparam logic [2:0] c_FLIT_HEADER  = 3'b001;
  localparam logic [2:0] c_FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] c_FLIT_TAIL    = 3'b100;

  // Port vector bit positions
  localparam int c_P_N = 0;
  localparam int c_P_E = 1;
  localparam int c_P_W = 2;
  localparam int c_P_S = 3;
  localparam int c_P_L = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_rxy;
  logic [3:0]       r_cx;
  logic [A_W-1:0]   r_cur;
  logic [4:0]       r_ports;
  logic [4:0]       w_ports_nxt;
  logic             r_route_err;
  logic             r_proto_err;
  logic             w_route_err_nxt;
  logic             w_proto_err_nxt;
  logic             w_cfg_load;

  logic [X_W-1:0]   w_x_dst;
  logic [X_W-1:0]   w_x_cur;
  logic [Y_W-1:0]   w_y_dst;
  logic [Y_W-1:0]   w_y_cur;
  logic             w_n1;
  logic             w_s1;
  logic             w_e1;
  logic             w_w1;
  logic [4:0]       w_route;

  assign w_x_dst = dst_addr[X_W-1:0];
  assign w_y_dst = dst_addr[A_W-1:X_W];
  assign w_x_cur = r_cur[X_W-1:0];
  assign w_y_cur = r_cur[A_W-1:X_W];

  // Direction comparators: north is toward smaller y, east toward larger x
  assign w_n1 = (w_y_dst < w_y_cur);
  assign w_s1 = (w_y_cur < w_y_dst);
  assign w_e1 = (w_x_cur < w_x_dst);
  assign w_w1 = (w_x_dst < w_x_cur);

  // LBDR port equations; Rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, Cx = {Cs,Cw,Ce,Cn}
  assign w_route[c_P_N] = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & r_rxy[0]) |
                           (w_n1 & w_w1 & r_rxy[1])) & r_cx[0];
  assign w_route[c_P_E] = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & r_rxy[2]) |
                           (w_e1 & w_s1 & r_rxy[3])) & r_cx[1];
  assign w_route[c_P_W] = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & r_rxy[4]) |
                           (w_w1 & w_s1 & r_rxy[5])) & r_cx[2];
  assign w_route[c_P_S] = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & r_rxy[6]) |
                           (w_s1 & w_w1 & r_rxy[7])) & r_cx[3];
  assign w_route[c_P_L] = ~w_n1 & ~w_e1 & ~w_w1 & ~w_s1;

  // Next-state, next-port and error-pulse decode from the flit at the input
  always_comb begin
    w_state_nxt     = r_state;
    w_ports_nxt     = r_ports;
    w_route_err_nxt = 1'b0;
    w_proto_err_nxt = 1'b0;
    // Reconfiguration only while no route is open; header in the same
    // cycle still sees the old bits because w_route reads the registers.
    w_cfg_load      = cfg_we && (r_state == ST_IDLE);
    if (!empty) begin
      case (r_state)
        ST_IDLE: begin
          if (flit_id == c_FLIT_HEADER) begin
            if (|w_route) begin
              w_ports_nxt = w_route;
              w_state_nxt = ST_ACTIVE;
            end else begin
              w_ports_nxt     = '0;
              w_route_err_nxt = 1'b1;
            end
          end else begin
            w_proto_err_nxt = 1'b1;
          end
        end
        ST_ACTIVE: begin
          case (flit_id)
            c_FLIT_HEADER: begin
              // Unexpected header: flag it, then reroute as a fresh packet
              w_proto_err_nxt = 1'b1;
              if (|w_route) begin
                w_ports_nxt = w_route;
              end else begin
                w_ports_nxt     = '0;
                w_route_err_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
              end
            end
            c_FLIT_PAYLOAD: begin
              w_ports_nxt = r_ports;
            end
            c_FLIT_TAIL: begin
              w_ports_nxt = '0;
              w_state_nxt = ST_IDLE;
            end
            default: begin
              w_proto_err_nxt = 1'b1;
            end
          endcase
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_ports_nxt = '0;
        end
      endcase
    end
  end

  // State, configuration and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rxy       <= Rxy_rst;
      r_cx        <= Cx_rst;
      r_cur       <= cur_addr_rst;
      r_ports     <= '0;
      r_route_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ports     <= w_ports_nxt;
      r_route_err <= w_route_err_nxt;
      r_proto_err <= w_proto_err_nxt;
      if (w_cfg_load) begin
        r_rxy <= Rxy_cfg;
        r_cx  <= Cx_cfg;
      end
    end
  end

  assign Nport     = r_ports[c_P_N];
  assign Eport     = r_ports[c_P_E];
  assign Wport     = r_ports[c_P_W];
  assign Sport     = r_ports[c_P_S];
  assign Lport     = r_ports[c_P_L];
  assign busy      = (r_state == ST_ACTIVE);
  assign route_err = r_route_err;
  assign proto_err = r_proto_err;

`ifdef LBDR_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of cycles on which any error pulse is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if ((r_route_err || r_proto_err) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbdr_reconf.sv
`default_nettype none
//============================================================================
// Module   : tb_lbdr_reconf
// Purpose  : Self-checking bench for lbdr_reconf: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a behavioural routing model.
// Revision : 1.0 - initial release
//============================================================================
module tb_lbdr_reconf;

  localparam int X_W = 2;
  localparam int Y_W = 2;
  localparam int A_W = X_W + Y_W;

  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] PAY = 3'b010;
  localparam logic [2:0] TAL = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           empty;
  logic [2:0]     flit_id;
  logic [A_W-1:0] dst_addr;
  logic [7:0]     Rxy_rst;
  logic [3:0]     Cx_rst;
  logic [A_W-1:0] cur_addr_rst;
  logic           cfg_we;
  logic [7:0]     Rxy_cfg;
  logic [3:0]     Cx_cfg;
  logic           Nport, Eport, Wport, Sport, Lport;
  logic           busy, route_err, proto_err;
  logic [7:0]     err_cnt;

  lbdr_reconf #(.X_W(X_W), .Y_W(Y_W), .A_W(A_W)) dut (
    .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .cur_addr_rst(cur_addr_rst),
    .cfg_we(cfg_we), .Rxy_cfg(Rxy_cfg), .Cx_cfg(Cx_cfg),
    .Nport(Nport), .Eport(Eport), .Wport(Wport), .Sport(Sport), .Lport(Lport),
    .busy(busy), .route_err(route_err), .proto_err(proto_err), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Port vector order: [0]=N [1]=E [2]=W [3]=S [4]=L
  bit             m_open;
  bit [4:0]       m_ports;
  bit             m_rerr, m_perr;
  bit [7:0]       m_rxy;
  bit [3:0]       m_cx;
  bit [A_W-1:0]   m_cur;
  int             m_cnt;

  // Which ports a destination may take: straight moves need only the link,
  // diagonal moves need the link plus the turn bit for that quadrant.
  function automatic bit [4:0] ref_route(input bit [7:0] rxy, input bit [3:0] cx,
                                         input bit [A_W-1:0] cur, input bit [A_W-1:0] dst);
    int dx, dy;
    bit [4:0] r;
    r  = '0;
    dx = int'(dst % (1 << X_W)) - int'(cur % (1 << X_W));
    dy = int'(dst / (1 << X_W)) - int'(cur / (1 << X_W));
    if (dx == 0 && dy == 0)       r[4] = 1'b1;
    else if (dx == 0 && dy < 0)   r[0] = cx[0];
    else if (dx == 0)             r[3] = cx[3];
    else if (dy == 0 && dx > 0)   r[1] = cx[1];
    else if (dy == 0)             r[2] = cx[2];
    else if (dy < 0 && dx > 0) begin r[0] = rxy[0] & cx[0]; r[1] = rxy[2] & cx[1]; end
    else if (dy < 0)           begin r[0] = rxy[1] & cx[0]; r[2] = rxy[4] & cx[2]; end
    else if (dx > 0)           begin r[3] = rxy[6] & cx[3]; r[1] = rxy[3] & cx[1]; end
    else                       begin r[3] = rxy[7] & cx[3]; r[2] = rxy[5] & cx[2]; end
    return r;
  endfunction

  task automatic model_step();
    bit       old_err;
    bit [4:0] rt;
    old_err = m_rerr | m_perr;
    if (rst) begin
      m_rxy = Rxy_rst; m_cx = Cx_rst; m_cur = cur_addr_rst;
      m_open = 0; m_ports = '0; m_rerr = 0; m_perr = 0; m_cnt = 0;
    end else begin
      m_rerr = 0; m_perr = 0;
      if (old_err && m_cnt < 255) m_cnt++;
      rt = ref_route(m_rxy, m_cx, m_cur, dst_addr);
      if (cfg_we && !m_open) begin m_rxy = Rxy_cfg; m_cx = Cx_cfg; end
      if (!empty) begin
        if (flit_id == HDR) begin
          if (m_open) m_perr = 1;
          if (rt != 0) begin m_ports = rt; m_open = 1; end
          else begin m_rerr = 1; m_ports = '0; m_open = 0; end
        end else if (flit_id == PAY) begin
          if (!m_open) m_perr = 1;
        end else if (flit_id == TAL) begin
          if (!m_open) m_perr = 1;
          else begin m_ports = '0; m_open = 0; end
        end else begin
          m_perr = 1;
        end
      end
    end
  endtask

  // Compare process: advance the model on each edge, check the DUT just after
  always @(posedge clk) begin
    int exp_cnt;
    model_step();
    #1;
    chk("model_outputs", {24'd0, Lport, Sport, Wport, Eport, Nport, busy, route_err, proto_err},
        {24'd0, m_ports, m_open, m_rerr, m_perr});
`ifdef LBDR_ERR_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("model_err_cnt", {24'd0, err_cnt}, exp_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit e, input logic [2:0] f,
                      input logic [A_W-1:0] d, input bit cw,
                      input logic [7:0] rc, input logic [3:0] cc);
    @(negedge clk);
    rst = r; empty = e; flit_id = f; dst_addr = d;
    cfg_we = cw; Rxy_cfg = rc; Cx_cfg = cc;
    @(posedge clk);
    #2;
  endtask

  task automatic flit(input logic [2:0] f, input logic [A_W-1:0] d);
    step(0, 0, f, d, 0, 8'd0, 4'd0);
  endtask

  task automatic idle();
    step(0, 1, PAY, '0, 0, 8'd0, 4'd0);
  endtask

  function automatic logic [31:0] ports_now();
    return {27'd0, Lport, Sport, Wport, Eport, Nport};
  endfunction

  initial begin
    rst = 1; empty = 1; flit_id = PAY; dst_addr = '0;
    Rxy_rst = 8'd60; Cx_rst = 4'hF; cur_addr_rst = 4'd5;
    cfg_we = 0; Rxy_cfg = '0; Cx_cfg = '0;

    // Reset state
    step(1, 1, PAY, '0, 0, 8'd0, 4'd0);
    chk("reset_ports", ports_now(), 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_errs", {30'd0, route_err, proto_err}, 0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 0);

    // Header to own address goes local
    flit(HDR, 4'd5);
    chk("local_Lport", ports_now(), 32'b10000);
    chk("local_busy", {31'd0, busy}, 1);
    flit(TAL, 4'd0);
    chk("local_close", ports_now(), 0);

    // North-east destination: Rne=0, Ren=1 so only east
    flit(HDR, 4'd2);
    chk("ne_Eport", ports_now(), 32'b00010);
    for (int i = 0; i < 3; i++) begin
      flit(PAY, 4'd0);
      chk("ne_hold_payload", ports_now(), 32'b00010);
    end
    idle();
    chk("ne_hold_empty", ports_now(), 32'b00010);
    flit(TAL, 4'd0);
    chk("ne_after_tail", ports_now(), 0);
    chk("ne_busy_done", {31'd0, busy}, 0);

    // Disable east link, then an eastbound header cannot route
    step(0, 1, PAY, '0, 1, 8'd60, 4'hD);
    flit(HDR, 4'd6);
    chk("noroute_err", {31'd0, route_err}, 1);
    chk("noroute_ports", ports_now(), 0);
    chk("noroute_busy", {31'd0, busy}, 0);
    idle();
    chk("noroute_pulse_end", {31'd0, route_err}, 0);

    // Protocol errors: payload while idle, header while active
    flit(PAY, 4'd0);
    chk("idle_payload_perr", {31'd0, proto_err}, 1);
    flit(HDR, 4'd5);
    chk("reopen_local", ports_now(), 32'b10000);
    flit(HDR, 4'd1);
    chk("active_hdr_perr", {31'd0, proto_err}, 1);
    chk("active_hdr_Nport", ports_now(), 32'b00001);

    // Reset in the middle of a packet
    step(1, 0, PAY, '0, 0, 8'd0, 4'd0);
    chk("midrst_ports", ports_now(), 0);
    chk("midrst_busy_errs", {29'd0, busy, route_err, proto_err}, 0);

`ifdef LBDR_ERR_CNT_EN
    for (int i = 0; i < 300; i++) flit(PAY, 4'd0);
    idle();
    idle();
    chk("err_cnt_saturate", {24'd0, err_cnt}, 255);
    step(1, 1, PAY, '0, 0, 8'd0, 4'd0);
`endif

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [2:0] f;
      bit r;
      r = ($urandom_range(0, 149) == 0);
      if (r) begin
        Rxy_rst      = 8'($urandom);
        Cx_rst       = 4'($urandom);
        cur_addr_rst = A_W'($urandom);
      end
      sel = $urandom_range(0, 9);
      if (sel < 3)      f = HDR;
      else if (sel < 7) f = PAY;
      else if (sel < 9) f = TAL;
      else              f = 3'($urandom);
      step(r, ($urandom_range(0, 3) == 0), f, A_W'($urandom),
           ($urandom_range(0, 7) == 0), 8'($urandom), 4'($urandom));
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
